// File: rtl/issue_ctrl.sv
// issue_ctrl: dual-issue decision, register scoreboard and issue pipeline register.
package issue_pkg;
    typedef struct packed {
        logic [1:0][4:0] r_reg;
        logic [4:0]      w_reg;
    } reg_info_t;
    typedef struct packed {
        logic [31:0] pc;
        reg_info_t   register_info;
    } inst_t;
endpackage

module issue_ctrl
    import issue_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int WB_PORTS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  inst_t [1:0]              inst_i,
    input  logic [1:0]               inst_valid_i,
    input  logic [1:0]               long_lat_i,
    output logic [1:0]               issue_num_o,
    output logic                     stall_o,
    input  logic                     ex_ready_i,
    output inst_t [1:0]              is_inst_o,
    output logic [1:0]               is_valid_o,
    input  logic [WB_PORTS-1:0]      wb_valid_i,
    input  logic [WB_PORTS-1:0][4:0] wb_reg_i,
    input  logic                     flush_i
);
    logic [NREG-1:0] r_sb;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_sb;
    logic            w_out_free;
    logic            w_go;
    logic            w_iss0;
    logic            w_iss1;
    logic            w_raw;
    logic            w_waw;

    function automatic logic pend(input logic [4:0] r, input logic [NREG-1:0] sb);
        pend = (|r) & sb[r];
    endfunction

    function automatic logic haz(input inst_t i, input logic [NREG-1:0] sb);
        haz = pend(i.register_info.r_reg[0], sb) | pend(i.register_info.r_reg[1], sb) |
              pend(i.register_info.w_reg, sb);
    endfunction

    // Releases are applied before the hazard check so a writeback can wake its consumer in the same cycle
    always_comb begin
        w_clr = '0;
        for (int k = 0; k < WB_PORTS; k++)
            if (wb_valid_i[k]) w_clr[wb_reg_i[k]] = 1'b1;
    end

    assign w_sb       = r_sb & ~w_clr;
    assign w_out_free = ~is_valid_o[0] | ex_ready_i;
    assign w_go       = w_out_free & ~rst & ~flush_i;
    assign w_raw      = (|inst_i[0].register_info.w_reg) &
                        ((inst_i[1].register_info.r_reg[0] == inst_i[0].register_info.w_reg) |
                         (inst_i[1].register_info.r_reg[1] == inst_i[0].register_info.w_reg));
    assign w_waw      = (|inst_i[0].register_info.w_reg) &
                        (inst_i[1].register_info.w_reg == inst_i[0].register_info.w_reg);
    assign w_iss0     = w_go & inst_valid_i[0] & ~haz(inst_i[0], w_sb);
    assign w_iss1     = w_iss0 & inst_valid_i[1] & ~haz(inst_i[1], w_sb) & ~w_raw & ~w_waw &
                        ~long_lat_i[0];
    assign issue_num_o = {w_iss1, w_iss0 ^ w_iss1};
    assign stall_o     = ~w_out_free | rst;

    always_comb begin
        w_set = '0;
        if (w_iss0 & long_lat_i[0]) w_set[inst_i[0].register_info.w_reg] = 1'b1;
        if (w_iss1 & long_lat_i[1]) w_set[inst_i[1].register_info.w_reg] = 1'b1;
        w_set[0] = 1'b0;
    end

    // Set is OR-ed after the release so a new producer wins over the older one's writeback
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sb       <= '0;
            is_valid_o <= '0;
            is_inst_o  <= '0;
        end else begin
            r_sb <= flush_i ? '0 : (w_sb | w_set);
            if (flush_i)
                is_valid_o <= '0;
            else if (w_out_free) begin
                is_inst_o  <= inst_i;
                is_valid_o <= {w_iss1, w_iss0};
            end
        end
    end
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed vectors with a queue-based scoreboard and negedge monitor.
module tb_issue_ctrl;
    import issue_pkg::*;

    typedef struct {
        int          cyc;
        logic [1:0]  num;
        logic        stall;
        logic        chk_isv;
        logic [1:0]  isv;
        logic        chk_inst;
        inst_t       i0;
        inst_t       i1;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    inst_t [1:0]      inst_i;
    logic [1:0]       inst_valid_i;
    logic [1:0]       long_lat_i;
    logic [1:0]       issue_num_o;
    logic             stall_o;
    logic             ex_ready_i;
    inst_t [1:0]      is_inst_o;
    logic [1:0]       is_valid_o;
    logic [1:0]       wb_valid_i;
    logic [1:0][4:0]  wb_reg_i;
    logic             flush_i;

    exp_t  q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    inst_t e0 = '0;
    inst_t e1 = '0;
    logic  done = 1'b0;

    issue_ctrl #(.NREG(32), .WB_PORTS(2)) dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_valid_i(inst_valid_i),
        .long_lat_i(long_lat_i), .issue_num_o(issue_num_o), .stall_o(stall_o),
        .ex_ready_i(ex_ready_i), .is_inst_o(is_inst_o), .is_valid_o(is_valid_o),
        .wb_valid_i(wb_valid_i), .wb_reg_i(wb_reg_i), .flush_i(flush_i)
    );

    always #5 clk = ~clk;

    function automatic inst_t mk(input int tag, input int w, input int r0, input int r1);
        inst_t t;
        t.pc = 32'h1000 + 32'(tag) * 4;
        t.register_info.w_reg = 5'(w);
        t.register_info.r_reg[0] = 5'(r0);
        t.register_info.r_reg[1] = 5'(r1);
        return t;
    endfunction

    task automatic step(input inst_t a, input inst_t b, input logic [1:0] v, input logic [1:0] ll,
                        input logic exr, input logic wbv, input int wbr, input logic fl,
                        input logic rs, input logic [1:0] num, input logic stall,
                        input logic chk_isv, input logic [1:0] isv);
        exp_t x;
        @(posedge clk);
        #1;
        rst = rs; inst_i[0] = a; inst_i[1] = b; inst_valid_i = v; long_lat_i = ll;
        ex_ready_i = exr; wb_valid_i = {1'b0, wbv}; wb_reg_i[0] = 5'(wbr); wb_reg_i[1] = 5'd0;
        flush_i = fl;
        x.cyc = cyc; x.num = num; x.stall = stall; x.chk_isv = chk_isv; x.isv = isv;
        x.chk_inst = chk_isv & (rs | (isv != 2'b00)); x.i0 = e0; x.i1 = e1;
        q.push_back(x);
        if (rs) begin e0 = '0; e1 = '0; end
        else if (!fl && !stall) begin e0 = a; e1 = b; end
        cyc++;
    endtask

    always @(negedge clk) begin
        if (!done && q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            checks++;
            if (issue_num_o !== x.num) begin
                errors++;
                $display("FAIL issue_num cyc%0d: got %0d want %0d", x.cyc, issue_num_o, x.num);
            end
            checks++;
            if (stall_o !== x.stall) begin
                errors++;
                $display("FAIL stall cyc%0d: got %0b want %0b", x.cyc, stall_o, x.stall);
            end
            if (x.chk_isv) begin
                checks++;
                if (is_valid_o !== x.isv) begin
                    errors++;
                    $display("FAIL is_valid cyc%0d: got %b want %b", x.cyc, is_valid_o, x.isv);
                end
            end
            if (x.chk_inst) begin
                checks++;
                if (is_inst_o[0] !== x.i0 || is_inst_o[1] !== x.i1) begin
                    errors++;
                    $display("FAIL is_inst cyc%0d: got %h/%h want %h/%h", x.cyc,
                             is_inst_o[0], is_inst_o[1], x.i0, x.i1);
                end
            end
        end
    end

    initial begin
        inst_t A, B, C, D, F, G, H, I, L, U, M, N, P, Q, Z;
        A = mk(1, 4, 5, 6);   B = mk(2, 7, 8, 9);
        C = mk(3, 4, 1, 2);   D = mk(4, 5, 4, 3);
        F = mk(5, 0, 1, 2);   G = mk(6, 6, 0, 3);
        H = mk(7, 8, 1, 2);   I = mk(8, 8, 3, 5);
        L = mk(9, 4, 1, 2);   U = mk(10, 5, 4, 1);
        M = mk(11, 9, 1, 2);  N = mk(12, 10, 9, 1);
        P = mk(13, 11, 1, 2); Q = mk(14, 12, 3, 5);
        Z = '0;
        rst = 1'b1; inst_i = '0; inst_valid_i = '0; long_lat_i = '0; ex_ready_i = 1'b1;
        wb_valid_i = '0; wb_reg_i = '0; flush_i = 1'b0;
        //   a  b  v      ll     exr   wbv   wbr fl    rs    num    stall chk   isv
        step(A, B, 2'b11, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 2'b00);
        step(A, B, 2'b11, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 2'b00);
        step(A, B, 2'b11, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2'b00);
        step(C, D, 2'b11, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b11);
        step(D, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b01);
        step(F, G, 2'b11, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2'b01);
        step(H, I, 2'b11, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b11);
        step(I, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b01);
        step(L, Z, 2'b01, 2'b01, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b01);
        step(U, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        step(U, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        step(U, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        step(U, Z, 2'b01, 2'b00, 1'b1, 1'b1, 4, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00);
        step(Z, Z, 2'b00, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01);
        step(A, B, 2'b11, 2'b00, 1'b0, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 2'b01);
        step(A, B, 2'b11, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 2'b01);
        step(Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b11);
        step(L, Z, 2'b01, 2'b01, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00);
        step(U, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        step(U, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00);
        step(A, B, 2'b10, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        step(Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        step(M, Z, 2'b01, 2'b01, 1'b1, 1'b1, 9, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00);
        step(N, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        step(N, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        step(N, Z, 2'b01, 2'b00, 1'b1, 1'b1, 9, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00);
        step(Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        step(P, Q, 2'b11, 2'b01, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b00);
        step(Q, Z, 2'b01, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 2'b01);
        step(Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 2'b01);
        step(Z, Z, 2'b00, 2'b00, 1'b1, 1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'b00);
        @(negedge clk);
        @(posedge clk);
        done = 1'b1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Backend-side consumer of the frontend decoded-instruction queue.
- Each cycle it looks at up to two in-order head instructions and decides how many to pop: `issue_num_o` is 0, 1 or 2.
- Issue is blocked by intra-pair hazards and by a register scoreboard that tracks long-latency destinations.
- Issued instructions are latched into a pipeline register that feeds the execute stage. `stall_o` drives the frontend's backend-stall input.

Parameters:
- `NREG`, 32, number of architectural GPRs (scoreboard width).
- `WB_PORTS`, 2, number of scoreboard release (writeback) ports.

Ports:
- `clk`, input, 1, clock.
- `rst`, input, 1, reset; synchronous, active-high.
- `inst_i`, input, `inst_t[1:0]`, queue head; slot 0 is older.
- `inst_valid_i`, input, 2, per-slot valid; only `2'b00`, `2'b01` and `2'b11` are legal.
- `long_lat_i`, input, 2, per-slot flag: this instruction's result comes from a writeback port (load/div), not the bypass network.
- `issue_num_o`, output, 2, number of entries popped this cycle (0/1/2).
- `stall_o`, output, 1, tells the queue to hold its read side.
- `ex_ready_i`, input, 1, execute stage accepts the pipeline register this cycle.
- `is_inst_o`, output, `inst_t[1:0]`, registered issued pair.
- `is_valid_o`, output, 2, registered per-slot valid.
- `wb_valid_i`, input, `WB_PORTS`, writeback release strobes.
- `wb_reg_i`, input, `WB_PORTS`x5, released register index.
- `flush_i`, input, 1, pipeline flush, asserted at commit.

Behaviour:
- **Reset** (`rst`=1 at posedge):
  - `is_valid_o`=0, `is_inst_o`=0, scoreboard=0.
  - Outputs remain consistent in the reset cycle: `issue_num_o`=0, `stall_o`=1.
- **Register fields**: hazard checks use `register_info.r_reg[0..1]` and `register_info.w_reg`. Register index 0 never causes a hazard and is never set in the scoreboard.
- **Output register**: `out_free` = ~`is_valid_o`[0] | `ex_ready_i`.
- **`stall_o`** = ~`out_free`. When `stall_o`=1, `issue_num_o`=0 and the output register holds.
- **Slot 0 can issue** when `out_free` & `inst_valid_i`[0], and neither its `r_reg` nor its `w_reg` is pending in the scoreboard. The scoreboard value used is the one after same-cycle writeback releases (bypass), so a release and a dependent issue may occur in the same cycle.
- **Slot 1 can issue** only when all of the following hold:
  - slot 0 issues;
  - `inst_valid_i`[1] is set;
  - slot 1 has no scoreboard hazard (same rule as slot 0);
  - no RAW: slot 1 `r_reg` ≠ slot 0 `w_reg`;
  - no WAW: slot 1 `w_reg` ≠ slot 0 `w_reg`, ignoring index 0;
  - `long_lat_i`[0]=0, i.e. nothing pairs behind a long-latency op.
- **`issue_num_o`** = {both issue, exactly one issues}. This is combinational, the same cycle the queue samples it.
- **Latching (`out_free`=1)**:
  - `is_inst_o` ← `inst_i`;
  - `is_valid_o` ← {slot1 issues, slot0 issues};
  - a pair that is not issued loads `is_valid_o`=0, i.e. a bubble.
- **Scoreboard update** for every issued slot with `long_lat_i`=1 and `w_reg`≠0: set bit `w_reg`.
- **Scoreboard release**: each `wb_valid_i`[k] clears bit `wb_reg_i`[k].
- **Set and clear on the same index in the same cycle**: set wins. The release belongs to the older producer.
- **Flush** (`flush_i`=1):
  - next cycle `is_valid_o`=0 and scoreboard=0;
  - `issue_num_o`=0 in the flush cycle;
  - takes priority over issue and ex-hold.
- **Flush contract**: `flush_i` is raised only after all older long-latency ops have written back, so clearing the scoreboard cannot lose a pending release.
- **Illegal valid pattern**: `inst_valid_i`=`2'b10` is treated as `2'b00`.
- **Latency**: 0 cycles from queue head to `issue_num_o`; 1 cycle to `is_*_o`.

Test Plan:
- **Independent pair**: `add r4,r5,r6` + `add r7,r8,r9`, valid=`11`, `ex_ready`=1 -> `issue_num`=2; next cycle `is_valid_o`=`11`, `is_inst_o` matches the inputs.
- **RAW and WAW in pair**:
  - slot0 writes r4, slot1 reads r4 -> `issue_num`=1, then slot1 issues alone the next cycle (`issue_num`=1).
  - slot0 writes r0, slot1 reads r0 -> `issue_num`=2.
- **Load-use**:
  - `ld r4` (`long_lat`=1) issues; a following `add r5,r4,r1` sees `issue_num`=0 for 3 cycles.
  - `wb_valid`=1, `wb_reg`=4 in cycle 4 -> same cycle `issue_num`=1.
- **Backpressure**: `is_valid_o`=`01`, `ex_ready`=0 for 2 cycles -> `stall_o`=1, `issue_num`=0, `is_*_o` stable; `ex_ready`=1 -> `stall_o`=0 and the next pair latches.
- **Flush mid-wait**: r4 pending, `flush_i`=1 -> next cycle scoreboard=0 and `is_valid_o`=0; a reader of r4 now issues (`issue_num`≥1).
- **Reset and corner cases**:
  - `rst`=1 with valid=`11` -> `issue_num`=0, `is_valid_o`=0 after the edge.
  - valid=`10` -> `issue_num`=0.
  - set and release of r9 in the same cycle -> r9 stays pending.
